input_conditioner: RTL and testbench

//  Conditions raw DE1 push-buttons into the game-control inputs consumed by main_control/main_datapath.
//  - Synchronises and debounces the move keys into a clean user_move level.
//  - Turns the fire key into a rate-limited shoot request held until the controller acknowledges it,
//    so a press is never missed by the once-per-frame S_PREP_SHOOTING sample.

---
 rtl/input_conditioner.sv | 137 +++++++++++++
 tb/tb_input_conditioner.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Key conditioning for the game controls: synchronised/debounced move level plus a
// rate-limited, ack-held shoot request. Define AUTOFIRE_EN to repeat-fire while fire is held.

module input_conditioner_db #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic stable
);
  logic            s1_n, s2_n;
  logic            s2;
  logic [DB_W-1:0] cnt;

  assign s2 = ~s2_n;

  // Any sample matching the accepted level restarts the stability window.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_n   <= 1'b1;
      s2_n   <= 1'b1;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1_n <= key_n;
      s2_n <= s1_n;
      if (s2 == stable)
        cnt <= '0;
      else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= s2;
        cnt    <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end
endmodule

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18,
  parameter int COOLDOWN_CYCLES = 12500000,
  parameter int CD_W            = 24
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] key_n,
  input  logic       shoot_ack,
  output logic [1:0] user_move,
  output logic       shoot_req,
  output logic       ready
);
  localparam int NUM_KEYS = 3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COOLDOWN, S_WAIT_REL} state_t;

  logic [NUM_KEYS-1:0] key_stable;
  logic                left, fire, right;
  state_t              state;
  logic [CD_W-1:0]     cd;

  input_conditioner_db #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_db [NUM_KEYS-1:0] (
    .clk   (clk),
    .resetn(resetn),
    .key_n (key_n),
    .stable(key_stable)
  );

  assign left  = key_stable[2];
  assign fire  = key_stable[1];
  assign right = key_stable[0];

  // Opposing directions cancel rather than one taking priority.
  always_ff @(posedge clk) begin
    if (!resetn) user_move <= 2'b00;
    else         user_move <= {left & ~right, right & ~left};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cd        <= '0;
      shoot_req <= 1'b0;
      ready     <= 1'b1;
    end else begin
      case (state)
        S_IDLE:
          if (fire) begin
            state     <= S_REQ;
            shoot_req <= 1'b1;
            ready     <= 1'b0;
          end
        S_REQ:
          if (shoot_ack) begin
            state     <= S_COOLDOWN;
            cd        <= CD_W'(COOLDOWN_CYCLES - 1);
            shoot_req <= 1'b0;
          end
        S_COOLDOWN:
          if (cd == '0) begin
`ifdef AUTOFIRE_EN
            if (fire) begin
              state     <= S_REQ;
              shoot_req <= 1'b1;
            end else begin
              state <= S_IDLE;
              ready <= 1'b1;
            end
`else
            // A still-held key must be released before the next press can fire.
            if (fire)
              state <= S_WAIT_REL;
            else begin
              state <= S_IDLE;
              ready <= 1'b1;
            end
`endif
          end else
            cd <= cd - 1'b1;
        S_WAIT_REL:
          if (!fire) begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
        default: begin
          state     <= S_IDLE;
          shoot_req <= 1'b0;
          ready     <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them. DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=10.

module tb_input_conditioner;
  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] key_n;
  logic       shoot_ack;
  logic [1:0] user_move;
  logic       shoot_req;
  logic       ready;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    int         tid;
    logic [1:0] um;
    logic       req;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .DB_W           (18),
    .COOLDOWN_CYCLES(10),
    .CD_W           (24)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .key_n    (key_n),
    .shoot_ack(shoot_ack),
    .user_move(user_move),
    .shoot_req(shoot_req),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation that falls due at this cycle.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        checks++;
        if (user_move !== exp_q[i].um || shoot_req !== exp_q[i].req || ready !== exp_q[i].rdy) begin
          errors++;
          $display("FAIL t%0d cyc=%0d got user_move=%b shoot_req=%b ready=%b, expected %b %b %b",
                   exp_q[i].tid, cyc, user_move, shoot_req, ready,
                   exp_q[i].um, exp_q[i].req, exp_q[i].rdy);
        end
        exp_q.delete(i);
      end else if (exp_q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL t%0d cyc=%0d expectation for cyc %0d never compared",
                 exp_q[i].tid, cyc, exp_q[i].cyc);
        exp_q.delete(i);
      end
    end
  end

  task automatic expect_rng(input int tid, input int c0, input int c1,
                            input logic [1:0] um, input logic req, input logic rdy);
    exp_t e;
    for (int c = c0; c <= c1; c++) begin
      e.cyc = c; e.tid = tid; e.um = um; e.req = req; e.rdy = rdy;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    resetn    = 1'b0;
    key_n     = 3'b111;
    shoot_ack = 1'b0;

    // t0: reset state
    expect_rng(0, 1, 9, 2'b00, 1'b0, 1'b1);
    wait_to(3);
    resetn = 1'b1;

    // t1: 3-clk right tap never accepted
    wait_to(10);
    expect_rng(1, 11, 22, 2'b00, 1'b0, 1'b1);
    key_n = 3'b110;
    wait_to(13);
    key_n = 3'b111;

    // t2: right held then released
    wait_to(30);
    expect_rng(2, 31, 36, 2'b00, 1'b0, 1'b1);
    expect_rng(2, 37, 56, 2'b01, 1'b0, 1'b1);
    expect_rng(2, 57, 60, 2'b00, 1'b0, 1'b1);
    key_n = 3'b110;
    wait_to(50);
    key_n = 3'b111;

    // t3: left+right cancel, then right released
    wait_to(70);
    expect_rng(3, 71, 96, 2'b00, 1'b0, 1'b1);
    expect_rng(3, 97, 106, 2'b10, 1'b0, 1'b1);
    expect_rng(3, 107, 110, 2'b00, 1'b0, 1'b1);
    key_n = 3'b010;
    wait_to(90);
    key_n = 3'b011;
    wait_to(100);
    key_n = 3'b111;

    // t4: press, ack, press during cooldown, idle acks ignored
    wait_to(120);
    expect_rng(4, 121, 126, 2'b00, 1'b0, 1'b1);
    expect_rng(4, 127, 131, 2'b00, 1'b1, 1'b0);
    expect_rng(4, 132, 141, 2'b00, 1'b0, 1'b0);
`ifdef AUTOFIRE_EN
    expect_rng(4, 142, 146, 2'b00, 1'b1, 1'b0);
    expect_rng(4, 147, 156, 2'b00, 1'b0, 1'b0);
    expect_rng(4, 157, 165, 2'b00, 1'b0, 1'b1);
`else
    expect_rng(4, 142, 152, 2'b00, 1'b0, 1'b0);
    expect_rng(4, 153, 165, 2'b00, 1'b0, 1'b1);
`endif
    key_n = 3'b101;
    wait_to(127); key_n = 3'b111;
    wait_to(131); shoot_ack = 1'b1;
    wait_to(132); shoot_ack = 1'b0;
    wait_to(134); key_n = 3'b101;
    wait_to(146); key_n = 3'b111; shoot_ack = 1'b1;
    wait_to(147); shoot_ack = 1'b0;
    wait_to(158); shoot_ack = 1'b1;
    wait_to(159); shoot_ack = 1'b0;

    // t5: fire held 60 clks, each request acked one clk after it appears
    wait_to(170);
    expect_rng(5, 171, 176, 2'b00, 1'b0, 1'b1);
`ifdef AUTOFIRE_EN
    for (int k = 0; k < 5; k++) begin
      expect_rng(5, 177 + 12*k, 178 + 12*k, 2'b00, 1'b1, 1'b0);
      expect_rng(5, 179 + 12*k, 188 + 12*k, 2'b00, 1'b0, 1'b0);
    end
`else
    expect_rng(5, 177, 178, 2'b00, 1'b1, 1'b0);
    expect_rng(5, 179, 236, 2'b00, 1'b0, 1'b0);
`endif
    expect_rng(5, 237, 240, 2'b00, 1'b0, 1'b1);
    key_n = 3'b101;
    for (int k = 0; k < 5; k++) begin
      wait_to(178 + 12*k); shoot_ack = 1'b1;
      wait_to(179 + 12*k); shoot_ack = 1'b0;
    end
    wait_to(230); key_n = 3'b111;

    // t6: reset while requesting with a pending ack
    wait_to(250);
    expect_rng(6, 251, 256, 2'b00, 1'b0, 1'b1);
    expect_rng(6, 257, 260, 2'b01, 1'b1, 1'b0);
    expect_rng(6, 261, 270, 2'b00, 1'b0, 1'b1);
    key_n = 3'b100;
    wait_to(260); resetn = 1'b0; key_n = 3'b111; shoot_ack = 1'b1;
    wait_to(261); resetn = 1'b1;
    wait_to(264); shoot_ack = 1'b0;

    wait_to(272);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
